// File: rtl/lif_ring_reservoir.sv
// Ring reservoir of N leaky integrate-and-fire neurons. Each neuron integrates a
// masked shared input plus its predecessor's spike; spikes are counted per window.
module lif_ring_reservoir #(
   parameter int N          = 10,
   parameter int W          = 24,
   parameter int IN_W       = 16,
   parameter int THRESH     = 1024,
   parameter int LEAK_SHIFT = 4,
   parameter int W_REC      = 512,
   parameter int REFRAC     = 2,
   parameter int WINDOW     = 64,
   parameter int CW         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       ext_in,
   input  logic [N-1:0]          ext_mask,
   input  logic                  ring_en,
   output logic [N-1:0]          spikes,
   output logic                  win_valid,
   output logic [N*CW-1:0]       counts,
   input  logic [$clog2(N)-1:0]  rd_idx,
   output logic [W-1:0]          rd_vmem
);

   localparam int IW  = $clog2(N);
   localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   localparam logic signed [W+1:0] S_MAX    = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] S_MIN    = {3'b111, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] S_MAX_W  = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] S_MIN_W  = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W+1:0] REC_X    = (W+2)'(W_REC);
   localparam logic signed [W-1:0] THR      = W'(THRESH);
   localparam logic [RW-1:0]       REF_LOAD = RW'(REFRAC);
   localparam logic [WCW-1:0]      WIN_LAST = WCW'(WINDOW - 1);

   logic signed [W-1:0]    v_q [N];
   logic signed [W-1:0]    v_d [N];
   logic [RW-1:0]          ref_q [N];
   logic [RW-1:0]          ref_d [N];
   logic [N-1:0]           spk_q, spk_d;
   logic [N-1:0][CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0][CW-1:0]   counts_q, counts_d;
   logic [WCW-1:0]         win_cnt_q, win_cnt_d;
   logic                   win_valid_q, win_valid_d;

   logic signed [W-1:0]    s_sat [N];
   logic [N-1:0]           spk_nx;
   logic [N-1:0][CW-1:0]   cnt_sat;

   for (genvar g = 0; g < N; g++) begin : g_neuron
      localparam int PRED = (g == 0) ? N - 1 : g - 1;

      logic signed [W+1:0] v_ext;
      logic signed [W+1:0] inp_ext;
      logic signed [W+1:0] rec_ext;
      logic signed [W+1:0] s_full;
      logic signed [W-1:0] s_clip;
      logic [CW:0]         cnt_sum;

      // Two guard bits keep the leak/input/recurrent sum exact before clamping.
      always_comb begin
         v_ext   = {{2{v_q[g][W-1]}}, v_q[g]};
         inp_ext = ext_mask[g] ? {{(W+2-IN_W){ext_in[IN_W-1]}}, ext_in} : '0;
         rec_ext = (ring_en && spk_q[PRED]) ? REC_X : '0;
         s_full  = v_ext - (v_ext >>> LEAK_SHIFT) + inp_ext + rec_ext;
         if (s_full > S_MAX) begin
            s_clip = S_MAX_W;
         end else if (s_full < S_MIN) begin
            s_clip = S_MIN_W;
         end else begin
            s_clip = s_full[W-1:0];
         end
      end

      assign s_sat[g]   = s_clip;
      assign spk_nx[g]  = (ref_q[g] == '0) && (s_clip >= THR);
      assign cnt_sum    = {1'b0, cnt_q[g]} + {{CW{1'b0}}, spk_nx[g]};
      assign cnt_sat[g] = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
   end

   always_comb begin
      v_d         = v_q;
      ref_d       = ref_q;
      spk_d       = spk_q;
      cnt_d       = cnt_q;
      counts_d    = counts_q;
      win_cnt_d   = win_cnt_q;
      win_valid_d = 1'b0;
      if (in_valid) begin
         spk_d = spk_nx;
         for (int i = 0; i < N; i++) begin
            if (ref_q[i] != '0) begin
               v_d[i]   = '0;
               ref_d[i] = ref_q[i] - RW'(1);
            end else if (spk_nx[i]) begin
               v_d[i]   = '0;
               ref_d[i] = REF_LOAD;
            end else begin
               v_d[i]   = s_sat[i];
            end
         end
         // The closing step's own spikes belong to the window being latched.
         if (win_cnt_q == WIN_LAST) begin
            counts_d    = cnt_sat;
            cnt_d       = '0;
            win_cnt_d   = '0;
            win_valid_d = 1'b1;
         end else begin
            cnt_d       = cnt_sat;
            win_cnt_d   = win_cnt_q + WCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            v_q[i]   <= '0;
            ref_q[i] <= '0;
         end
         spk_q       <= '0;
         cnt_q       <= '0;
         counts_q    <= '0;
         win_cnt_q   <= '0;
         win_valid_q <= 1'b0;
      end else begin
         v_q         <= v_d;
         ref_q       <= ref_d;
         spk_q       <= spk_d;
         cnt_q       <= cnt_d;
         counts_q    <= counts_d;
         win_cnt_q   <= win_cnt_d;
         win_valid_q <= win_valid_d;
      end
   end

   always_comb begin
      rd_vmem = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_idx == IW'(i)) begin
            rd_vmem = v_q[i];
         end
      end
   end

   assign spikes    = spk_q;
   assign win_valid = win_valid_q;
   assign counts    = counts_q;

endmodule

// File: tb/tb_lif_ring_reservoir.sv
// Testbench for lif_ring_reservoir: directed scenarios plus randomized stimulus
// compared against an integer-arithmetic neuron model.
module tb_lif_ring_reservoir;

   localparam int N          = 10;
   localparam int W          = 18;
   localparam int IN_W       = 16;
   localparam int THRESH     = 1024;
   localparam int LEAK_SHIFT = 4;
   localparam int W_REC      = 1024;
   localparam int REFRAC     = 1;
   localparam int WINDOW     = 8;
   localparam int CW         = 2;
   localparam int IW         = $clog2(N);
   localparam int CNT_MAX    = (1 << CW) - 1;
   localparam int V_MAX      = (1 << (W - 1)) - 1;
   localparam int V_MIN      = -(1 << (W - 1));

   logic                 clk;
   logic                 rst;
   logic                 inValid;
   logic [IN_W-1:0]      extIn;
   logic [N-1:0]         extMask;
   logic                 ringEn;
   logic [N-1:0]         spikes;
   logic                 winValid;
   logic [N*CW-1:0]      counts;
   logic [IW-1:0]        rdIdx;
   logic [W-1:0]         rdVmem;

   int vectors;
   int miscompares;

   // Reference neuron state kept as plain integers.
   int mV [N];
   int mRef [N];
   int mCnt [N];
   int mCounts [N];
   bit mSpk [N];
   int mWin;
   bit mWinValid;

   lif_ring_reservoir #(
      .N(N), .W(W), .IN_W(IN_W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT),
      .W_REC(W_REC), .REFRAC(REFRAC), .WINDOW(WINDOW), .CW(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(inValid),
      .ext_in(extIn),
      .ext_mask(extMask),
      .ring_en(ringEn),
      .spikes(spikes),
      .win_valid(winValid),
      .counts(counts),
      .rd_idx(rdIdx),
      .rd_vmem(rdVmem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mV[i] = 0; mRef[i] = 0; mCnt[i] = 0; mCounts[i] = 0; mSpk[i] = 1'b0;
      end
      mWin = 0;
      mWinValid = 1'b0;
   endtask

   // One enabled step of the ring, applied from the neuron rules directly.
   task automatic modelStep(input bit valid, input int inSample, input logic [N-1:0] mask, input bit ring);
      bit nxt [N];
      int s;
      int c;
      if (!valid) begin
         mWinValid = 1'b0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (mRef[i] > 0) begin
            mV[i] = 0;
            mRef[i] = mRef[i] - 1;
            nxt[i] = 1'b0;
         end else begin
            s = mV[i] - (mV[i] >>> LEAK_SHIFT);
            if (mask[i]) s = s + inSample;
            if (ring && mSpk[(i + N - 1) % N]) s = s + W_REC;
            if (s > V_MAX) s = V_MAX;
            if (s < V_MIN) s = V_MIN;
            if (s >= THRESH) begin
               nxt[i] = 1'b1;
               mV[i] = 0;
               mRef[i] = REFRAC;
            end else begin
               nxt[i] = 1'b0;
               mV[i] = s;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         c = mCnt[i] + (nxt[i] ? 1 : 0);
         if (c > CNT_MAX) c = CNT_MAX;
         if (mWin == WINDOW - 1) begin
            mCounts[i] = c;
            mCnt[i] = 0;
         end else begin
            mCnt[i] = c;
         end
         mSpk[i] = nxt[i];
      end
      if (mWin == WINDOW - 1) begin
         mWin = 0;
         mWinValid = 1'b1;
      end else begin
         mWin = mWin + 1;
         mWinValid = 1'b0;
      end
   endtask

   function automatic logic [63:0] expSpikes();
      logic [63:0] r = '0;
      for (int i = 0; i < N; i++) r[i] = mSpk[i];
      return r;
   endfunction

   function automatic logic [63:0] expCounts();
      logic [63:0] r = '0;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(mCounts[i]);
      return r;
   endfunction

   function automatic logic [63:0] expVmem(input int idx);
      logic [W-1:0] t;
      if (idx >= N) return '0;
      t = W'(mV[idx]);
      return {{(64-W){1'b0}}, t};
   endfunction

   // Drive one cycle of inputs, step the model, and compare all outputs.
   task automatic applyStimulus(input bit valid, input int inSample, input logic [N-1:0] mask,
                                input bit ring, input int idx);
      @(negedge clk);
      inValid = valid;
      extIn   = IN_W'(inSample);
      extMask = mask;
      ringEn  = ring;
      rdIdx   = IW'(idx);
      @(posedge clk);
      #1;
      modelStep(valid, inSample, mask, ring);
      checkOutput("spikes", {{(64-N){1'b0}}, spikes}, expSpikes());
      checkOutput("win_valid", {63'd0, winValid}, {63'd0, mWinValid});
      checkOutput("counts", {{(64-N*CW){1'b0}}, counts}, expCounts());
      checkOutput("rd_vmem", {{(64-W){1'b0}}, rdVmem}, expVmem(idx));
   endtask

   // Asynchronous reset between edges; outputs must clear before the next edge.
   task automatic doReset();
      #2;
      inValid = 1'b0;
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_spikes", {{(64-N){1'b0}}, spikes}, 64'd0);
      checkOutput("rst_win_valid", {63'd0, winValid}, 64'd0);
      checkOutput("rst_counts", {{(64-N*CW){1'b0}}, counts}, 64'd0);
      checkOutput("rst_vmem", {{(64-W){1'b0}}, rdVmem}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int sample;
      vectors = 0;
      miscompares = 0;
      rst = 1'b0;
      inValid = 1'b0;
      extIn = '0;
      extMask = '0;
      ringEn = 1'b0;
      rdIdx = IW'(3);
      modelReset();
      #3;
      checkOutput("por_spikes", {{(64-N){1'b0}}, spikes}, 64'd0);
      checkOutput("por_counts", {{(64-N*CW){1'b0}}, counts}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Integrate and fire with a constant input and no recurrence.
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 256, '1, 1'b0, 3);
         if (k == 1) checkOutput("int_v256", {{(64-W){1'b0}}, rdVmem}, 64'd256);
         if (k == 4) checkOutput("int_v932", {{(64-W){1'b0}}, rdVmem}, 64'd932);
         if (k == 5) checkOutput("int_fire", {{(64-N){1'b0}}, spikes}, 64'h3FF);
      end

      // Single spike travelling around the ring.
      doReset();
      applyStimulus(1'b1, 1024, 10'h001, 1'b1, 0);
      checkOutput("ring_seed", {{(64-N){1'b0}}, spikes}, 64'h001);
      for (int k = 1; k <= N + 1; k++) begin
         applyStimulus(1'b1, 0, '0, 1'b1, 0);
         checkOutput("ring_hop", {{(64-N){1'b0}}, spikes}, 64'd1 << (k % N));
      end

      // Without recurrence the seed spike does not propagate.
      doReset();
      applyStimulus(1'b1, 1024, 10'h001, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 0, '0, 1'b0, 0);
         checkOutput("ring_off", {{(64-N){1'b0}}, spikes}, 64'd0);
      end

      // Saturating counter with a stall inside the window.
      doReset();
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 2048, '1, 1'b0, 1);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 2048, '1, 1'b0, 1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2048, '1, 1'b0, 1);
      checkOutput("win_early", {63'd0, winValid}, 64'd0);
      applyStimulus(1'b1, 2048, '1, 1'b0, 1);
      checkOutput("win_pulse", {63'd0, winValid}, 64'd1);
      checkOutput("cnt_sat", {{(64-N*CW){1'b0}}, counts}, 64'hFFFFF);

      // Negative membrane saturation and out-of-range readout.
      doReset();
      for (int k = 0; k < 12; k++) applyStimulus(1'b1, -32768, '1, 1'b0, 3);
      checkOutput("v_clamp", {{(64-W){1'b0}}, rdVmem}, 64'h20000);
      applyStimulus(1'b1, -32768, '1, 1'b0, 12);
      checkOutput("rd_oob", {{(64-W){1'b0}}, rdVmem}, 64'd0);

      // Randomized traffic with a reset landing mid-window.
      doReset();
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 9))
            0:       sample = -32768;
            1:       sample = 32767;
            default: sample = int'($urandom_range(0, 3000)) - 1200;
         endcase
         applyStimulus($urandom_range(0, 3) != 0, sample, N'($urandom),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         if (k == 301) doReset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
